ankka_v_issue_core: RTL and testbench

// - Parametrised successor to the single-shot fetch/ALU top level.
// - Buffers instructions in a FIFO and decodes RV32I OP/OP-IMM instructions.
// - Executes them against an internal register file and presents results on a valid/ready port.
// - Sits between the instruction source and the writeback/trace consumer; sustains one instruction per cycle.

---
 rtl/ankka_v_pkg.sv | 43 ++++
 rtl/ankka_v_issue_core_if.sv | 26 ++
 rtl/ankka_v_instr_fifo.sv | 52 +++++
 rtl/ankka_v_issue_core.sv | 155 +++++++++++++++
 tb/tb_ankka_v_issue_core.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ankka_v_pkg.sv
// Shared RV32I OP/OP-IMM encodings and instruction field helpers for the issue core.
package ankka_v_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        alu_op_t     op;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [11:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [31:0] word);
        instr_fields_t f;
        f.funct7 = word[31:25];
        f.rs2    = word[24:20];
        f.rs1    = word[19:15];
        f.op     = alu_op_t'(word[14:12]);
        f.rd     = word[11:7];
        f.opcode = word[6:0];
        f.imm    = word[31:20];
        return f;
    endfunction

endpackage

// File: rtl/ankka_v_issue_core_if.sv
// Instruction-in / result-out handshake bundle of the issue core.
interface ankka_v_issue_core_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
);
    logic [31:0]                   instr_in;
    logic                          instr_valid;
    logic                          instr_ready;
    logic                          flush;
    logic                          res_valid;
    logic                          res_ready;
    logic [XLEN-1:0]               res_data;
    logic [4:0]                    res_rd;
    logic                          res_illegal;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport slave (
        input  instr_in, instr_valid, flush, res_ready,
        output instr_ready, res_valid, res_data, res_rd, res_illegal, fifo_count
    );

    modport master (
        output instr_in, instr_valid, flush, res_ready,
        input  instr_ready, res_valid, res_data, res_rd, res_illegal, fifo_count
    );
endinterface

// File: rtl/ankka_v_instr_fifo.sv
// Synchronous instruction FIFO with wrap-bit pointers, occupancy count and flush.
module ankka_v_instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    // Head entry is visible combinationally so issue can decode it in the pop cycle.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/ankka_v_issue_core.sv
// Buffered single-stage RV32I OP/OP-IMM issue core: FIFO -> decode/ALU -> result register + regfile.
module ankka_v_issue_core
    import ankka_v_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_REGS   = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    ankka_v_issue_core_if.slave        bus
);
    localparam int RIDX = $clog2(NUM_REGS);
    localparam int SW   = $clog2(XLEN);

    logic            fifo_full;
    logic            fifo_empty;
    logic [31:0]     fifo_word;
    logic            push;
    logic            pop;

    logic            res_valid_reg;
    logic [XLEN-1:0] res_data_reg;
    logic [4:0]      res_rd_reg;
    logic            res_illegal_reg;

    logic [XLEN-1:0] regs_reg [NUM_REGS];

    instr_fields_t   f;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_val;
    logic            alt;
    logic            legal;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] exec_data;
    logic            rf_we;

    // No bypass: a full FIFO refuses input even if it pops this cycle.
    assign push = bus.instr_valid && !fifo_full && !bus.flush;
    assign pop  = !fifo_empty && (!res_valid_reg || bus.res_ready);

    ankka_v_instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (bus.flush),
        .wr_en   (push),
        .wr_data (bus.instr_in),
        .rd_en   (pop),
        .rd_data (fifo_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.fifo_count)
    );

    assign bus.instr_ready = !fifo_full;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_data    = res_data_reg;
    assign bus.res_rd      = res_rd_reg;
    assign bus.res_illegal = res_illegal_reg;

    always_comb begin
        f       = split_instr(fifo_word);
        imm_val = {{(XLEN-12){f.imm[11]}}, f.imm};
        op_a    = '0;
        rs2_val = '0;
        alt     = 1'b0;
        legal   = 1'b0;

        if (f.rs1 != 5'd0 && 32'(f.rs1) < NUM_REGS) op_a    = regs_reg[f.rs1[RIDX-1:0]];
        if (f.rs2 != 5'd0 && 32'(f.rs2) < NUM_REGS) rs2_val = regs_reg[f.rs2[RIDX-1:0]];
        op_b = rs2_val;

        case (f.opcode)
            OPC_OP: begin
                op_b = rs2_val;
                if (f.funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (f.funct7 == F7_ALT && (f.op == ALU_ADD || f.op == ALU_SR)) begin
                    legal = 1'b1;
                    alt   = 1'b1;
                end
                if (32'(f.rs2) >= NUM_REGS) legal = 1'b0;
            end
            OPC_OP_IMM: begin
                op_b = imm_val;
                case (f.op)
                    ALU_SLL: legal = (f.funct7 == F7_BASE);
                    ALU_SR: begin
                        if (f.funct7 == F7_BASE) begin
                            legal = 1'b1;
                        end else if (f.funct7 == F7_ALT) begin
                            legal = 1'b1;
                            alt   = 1'b1;
                        end
                    end
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (32'(f.rd) >= NUM_REGS || 32'(f.rs1) >= NUM_REGS) legal = 1'b0;
    end

    always_comb begin
        alu_res = '0;
        case (f.op)
            ALU_ADD:  alu_res = alt ? (op_a - op_b) : (op_a + op_b);
            ALU_SLL:  alu_res = op_a << op_b[SW-1:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SR:   alu_res = alt ? XLEN'($signed(op_a) >>> op_b[SW-1:0])
                                    : (op_a >> op_b[SW-1:0]);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = '0;
        endcase
    end

    assign exec_data = legal ? alu_res : '0;
    assign rf_we     = pop && !bus.flush && legal && (f.rd != 5'd0);

    // Regfile and result register load on the same edge, so a back-to-back dependent pop sees the new value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
        end else if (rf_we) begin
            regs_reg[f.rd[RIDX-1:0]] <= exec_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            res_rd_reg      <= '0;
            res_illegal_reg <= 1'b0;
        end else if (bus.flush) begin
            res_valid_reg   <= 1'b0;
        end else if (pop) begin
            res_valid_reg   <= 1'b1;
            res_data_reg    <= exec_data;
            res_rd_reg      <= f.rd;
            res_illegal_reg <= !legal;
        end else if (bus.res_ready) begin
            res_valid_reg   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ankka_v_issue_core.sv
// Randomised bench for the issue core against a queue-based instruction-level reference model.
module tb_ankka_v_issue_core;
    localparam int DEPTH = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    ankka_v_issue_core_if #(.XLEN(32), .FIFO_DEPTH(DEPTH)) bus ();

    ankka_v_issue_core #(
        .XLEN       (32),
        .FIFO_DEPTH (DEPTH),
        .NUM_REGS   (32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_q [$];
    logic [31:0] m_regs [32];
    bit          m_rv;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    bit          m_ill;
    bit          m_full, m_push, m_pop;
    logic [31:0] m_word;
    logic [37:0] retired [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ret(input string nm, input int idx, input logic [37:0] exp);
        total++;
        if (idx >= retired.size() || retired[idx] !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (retired=%0d)", nm,
                     (idx < retired.size()) ? retired[idx] : 38'h0, exp, retired.size());
        end
    endtask

    function automatic void ref_exec(input logic [31:0] w);
        logic [31:0] a, b, imm, v;
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          ok;
        rd  = w[11:7];
        f3  = w[14:12];
        rs1 = w[19:15];
        rs2 = w[24:20];
        f7  = w[31:25];
        a   = m_regs[rs1];
        b   = m_regs[rs2];
        imm = {{20{w[31]}}, w[31:20]};
        sh  = w[24:20];
        ok  = 1'b1;
        v   = 32'h0;
        if (w[6:0] == 7'h33) begin
            case ({f7, f3})
                10'h000: v = a + b;
                10'h100: v = a - b;
                10'h001: v = a << b[4:0];
                10'h002: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                10'h003: v = (a < b) ? 32'd1 : 32'd0;
                10'h004: v = a ^ b;
                10'h005: v = a >> b[4:0];
                10'h105: v = $signed(a) >>> b[4:0];
                10'h006: v = a | b;
                10'h007: v = a & b;
                default: ok = 1'b0;
            endcase
        end else if (w[6:0] == 7'h13) begin
            case (f3)
                3'd0: v = a + imm;
                3'd1: if (f7 == 7'h00) v = a << sh; else ok = 1'b0;
                3'd2: v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: v = (a < imm) ? 32'd1 : 32'd0;
                3'd4: v = a ^ imm;
                3'd5: begin
                    if (f7 == 7'h00)      v = a >> sh;
                    else if (f7 == 7'h20) v = $signed(a) >>> sh;
                    else                  ok = 1'b0;
                end
                3'd6: v = a | imm;
                default: v = a & imm;
            endcase
        end else begin
            ok = 1'b0;
        end
        m_ill  = !ok;
        m_rd   = rd;
        m_data = ok ? v : 32'h0;
        if (ok && rd != 5'd0) m_regs[rd] = v;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_q.delete();
            m_rv   = 1'b0;
            m_data = '0;
            m_rd   = '0;
            m_ill  = 1'b0;
            foreach (m_regs[i]) m_regs[i] = '0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_push = bus.instr_valid && !m_full;
            m_pop  = (m_q.size() != 0) && (!m_rv || bus.res_ready);
            if (bus.flush) begin
                m_q.delete();
                m_rv = 1'b0;
            end else begin
                if (m_pop) begin
                    m_word = m_q.pop_front();
                    ref_exec(m_word);
                    m_rv = 1'b1;
                end else if (bus.res_ready) begin
                    m_rv = 1'b0;
                end
                if (m_push) m_q.push_back(bus.instr_in);
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("instr_ready", 32'(bus.instr_ready), 32'(m_q.size() < DEPTH));
            chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
            chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
            if (m_rv) begin
                chk("res_data", bus.res_data, m_data);
                chk("res_rd", 32'(bus.res_rd), 32'(m_rd));
                chk("res_illegal", 32'(bus.res_illegal), 32'(m_ill));
            end
            if (bus.res_valid && bus.res_ready && !bus.flush) begin
                retired.push_back({bus.res_illegal, bus.res_rd, bus.res_data});
                $display("retire rd=%0d data=%h illegal=%0d", bus.res_rd, bus.res_data, bus.res_illegal);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_words(input logic [31:0] w [$]);
        foreach (w[i]) begin
            bus.instr_valid = 1'b1;
            bus.instr_in    = w[i];
            step();
        end
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_retired(input int n);
        int c = 0;
        while (retired.size() < n && c < 100) begin
            step();
            c++;
        end
        if (retired.size() < n) begin
            total++;
            bad++;
            $display("FAIL retire_timeout got=%0d want=%0d", retired.size(), n);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        int r;
        r   = $urandom_range(0, 9);
        f3  = 3'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom());
        if (r == 0) return $urandom();
        if ($urandom_range(0, 7) == 0) f7 = 7'($urandom());
        else f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (r < 5) begin
            rs2 = 5'($urandom_range(0, 7));
            return {f7, rs2, rs1, f3, rd, 7'h33};
        end
        if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom());
        return {f7, rs2, rs1, f3, rd, 7'h13};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_in    = '0;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_data", bus.res_data, 32'd0);
        step();

        // Latency: push at edge N, result visible after N+1
        bus.instr_valid = 1'b1;
        bus.instr_in    = 32'h00500093;
        step();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("lat_n_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("lat_n1_valid", 32'(bus.res_valid), 32'd1);
        chk("lat_n1_data", bus.res_data, 32'd5);
        chk("lat_n1_rd", 32'(bus.res_rd), 32'd1);
        repeat (3) step();

        // Back-to-back dependencies
        retired.delete();
        push_words('{32'h00500093, 32'h00108133, 32'h402081B3, 32'h4011D213});
        wait_retired(4);
        chk_ret("b2b_addi", 0, {1'b0, 5'd1, 32'd5});
        chk_ret("b2b_add",  1, {1'b0, 5'd2, 32'd10});
        chk_ret("b2b_sub",  2, {1'b0, 5'd3, 32'hFFFFFFFB});
        chk_ret("b2b_srai", 3, {1'b0, 5'd4, 32'hFFFFFFFD});
        chk("model_x4", m_regs[4], 32'hFFFFFFFD);
        repeat (3) step();

        // Illegal retire and x0 semantics
        retired.delete();
        push_words('{32'h00000073, 32'h00700013, 32'h000002B3});
        wait_retired(3);
        chk_ret("ecall",    0, {1'b1, 5'd0, 32'd0});
        chk_ret("addi_x0",  1, {1'b0, 5'd0, 32'd7});
        chk_ret("add_x5",   2, {1'b0, 5'd5, 32'd0});
        repeat (3) step();

        // Backpressure
        retired.delete();
        bus.res_ready = 1'b0;
        repeat (10) begin
            bus.instr_valid = 1'b1;
            bus.instr_in    = rand_instr();
            step();
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("bp_count", 32'(bus.fifo_count), 32'(DEPTH));
        chk("bp_ready", 32'(bus.instr_ready), 32'd0);
        chk("bp_valid", 32'(bus.res_valid), 32'd1);
        step();
        bus.res_ready = 1'b1;
        wait_retired(5);
        repeat (5) step();
        chk("bp_retired", 32'(retired.size()), 32'd5);

        // Flush with three buffered and one pending result
        retired.delete();
        bus.res_ready = 1'b0;
        push_words('{32'h00900313, 32'h00108133, 32'h00108133, 32'h00108133});
        @(negedge clk);
        chk("fl_pre_count", 32'(bus.fifo_count), 32'd3);
        chk("fl_pre_valid", 32'(bus.res_valid), 32'd1);
        chk("fl_pre_data", bus.res_data, 32'd9);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fl_count", 32'(bus.fifo_count), 32'd0);
        chk("fl_valid", 32'(bus.res_valid), 32'd0);
        step();
        bus.res_ready = 1'b1;
        push_words('{32'h000303B3});
        wait_retired(1);
        chk_ret("fl_keep_x6", 0, {1'b0, 5'd7, 32'd9});
        repeat (3) step();

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 2500; i++) begin
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr_in    = rand_instr();
            bus.res_ready   = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 60) == 0);
            step();
            if (i == 1200) begin
                bus.instr_valid = 1'b1;
                bus.flush       = 1'b0;
                resetn          = 1'b0;
                #1;
                chk("arst_valid", 32'(bus.res_valid), 32'd0);
                chk("arst_count", 32'(bus.fifo_count), 32'd0);
                chk("arst_data", bus.res_data, 32'd0);
                chk("arst_illegal", 32'(bus.res_illegal), 32'd0);
                step();
                resetn          = 1'b1;
                bus.instr_valid = 1'b0;
                bus.res_ready   = 1'b1;
                step();
                retired.delete();
                push_words('{32'h00008433});
                wait_retired(1);
                chk_ret("arst_x1_zero", 0, {1'b0, 5'd8, 32'd0});
            end
        end
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.res_ready   = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
